// File: rtl/tpu_log_pkg.sv
// Shared types and constants for the TPU result logger.
// Optional feature macro: TPU_LOG_TIMESTAMP_EN (adds a 16-bit cycle stamp per record).
package tpu_log_pkg;

  localparam logic [3:0] MLP_IDLE_STATE = 4'd0;
  localparam int SEQ_W     = 8;
  localparam int TS_W      = 16;
  localparam int LAYER_W   = 3;
  localparam int LOG_ACC_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOGGING = 2'd2,
    DONE    = 2'd3
  } log_state_t;

  // Canonical record layout at the default accumulator width.
  typedef struct packed {
    logic [LOG_ACC_W-1:0] acc0;
    logic [LOG_ACC_W-1:0] acc1;
    logic [LAYER_W-1:0]   layer;
    logic [SEQ_W-1:0]     seq;
`ifdef TPU_LOG_TIMESTAMP_EN
    logic [TS_W-1:0]      ts;
`endif
  } log_record_t;

endpackage

// File: rtl/log_fifo.sv
// First-word-fall-through circular record buffer; when empty the read side
// keeps presenting the last record popped.
module log_fifo
  import tpu_log_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type rec_t = log_record_t
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  rec_t                     wdata,
  output rec_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rec_t             mem [DEPTH];
  rec_t             last_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tpu_result_logger.sv
// Captures one record per rising edge of mlp_acc_valid during an armed MLP run.
// Optional feature macro: TPU_LOG_TIMESTAMP_EN (per-record cycle stamp, rd_timestamp port).
module tpu_result_logger
  import tpu_log_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    clear,
  input  logic [3:0]              mlp_state,
  input  logic [LAYER_W-1:0]      mlp_layer,
  input  logic                    mlp_acc_valid,
  input  logic [ACC_W-1:0]        mlp_acc0,
  input  logic [ACC_W-1:0]        mlp_acc1,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [ACC_W-1:0]        rd_acc0,
  output logic [ACC_W-1:0]        rd_acc1,
  output logic [LAYER_W-1:0]      rd_layer,
  output logic [SEQ_W-1:0]        rd_seq,
`ifdef TPU_LOG_TIMESTAMP_EN
  output logic [TS_W-1:0]         rd_timestamp,
`endif
  output logic [1:0]              log_state,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [7:0]              dropped_cnt
);

  typedef struct packed {
    logic [ACC_W-1:0]   acc0;
    logic [ACC_W-1:0]   acc1;
    logic [LAYER_W-1:0] layer;
    logic [SEQ_W-1:0]   seq;
`ifdef TPU_LOG_TIMESTAMP_EN
    logic [TS_W-1:0]    ts;
`endif
  } rec_t;

  log_state_t       state, state_next;
  logic             flush;
  logic             acc_valid_q;
  logic             capture;
  logic             drop;
  logic             full;
  logic             empty;
  logic [SEQ_W-1:0] seq;
  rec_t             wr_rec;
  rec_t             head;

  // clear behaves exactly like reset; the caller's priority order is irrelevant here.
  assign flush   = rst || clear;
  assign capture = (state == LOGGING) && mlp_acc_valid && !acc_valid_q;
  // A full buffer only loses the record when the reader is not popping this cycle.
  assign drop    = capture && full && !rd_ready;

  always_ff @(posedge clk) begin
    if (flush) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: defaults first so every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = ARMED;
      ARMED:   if (mlp_state != MLP_IDLE_STATE) state_next = LOGGING;
      LOGGING: if (mlp_state == MLP_IDLE_STATE) state_next = DONE;
      DONE:    if (arm) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      acc_valid_q <= 1'b0;
      seq         <= '0;
      overflow    <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      acc_valid_q <= mlp_acc_valid;
      if (capture) seq <= seq + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 1'b1;
      end
    end
  end

`ifdef TPU_LOG_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (flush)                                        ts <= '0;
    else if (state == ARMED && state_next == LOGGING) ts <= '0;
    else if (state == LOGGING)                        ts <= ts + 1'b1;
  end

  assign wr_rec.ts    = ts;
  assign rd_timestamp = head.ts;
`endif

  assign wr_rec.acc0  = mlp_acc0;
  assign wr_rec.acc1  = mlp_acc1;
  assign wr_rec.layer = mlp_layer;
  assign wr_rec.seq   = seq;

  log_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk   (clk),
    .flush (flush),
    .push  (capture),
    .pop   (rd_ready),
    .wdata (wr_rec),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign rd_valid  = !empty;
  assign rd_acc0   = head.acc0;
  assign rd_acc1   = head.acc1;
  assign rd_layer  = head.layer;
  assign rd_seq    = head.seq;
  assign log_state = state;

endmodule

// File: tb/tb_tpu_result_logger.sv
// Scoreboard bench for tpu_result_logger: a queue-based reference model predicts
// records and status; a negedge monitor compares the DUT against it every cycle.
module tb_tpu_result_logger;
  import tpu_log_pkg::*;

  localparam int DEPTH = 16;
  localparam int ACC_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             arm = 1'b0;
  logic             clear = 1'b0;
  logic [3:0]       mlp_state = 4'd0;
  logic [2:0]       mlp_layer = 3'd0;
  logic             mlp_acc_valid = 1'b0;
  logic [ACC_W-1:0] mlp_acc0 = '0;
  logic [ACC_W-1:0] mlp_acc1 = '0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [ACC_W-1:0] rd_acc0;
  logic [ACC_W-1:0] rd_acc1;
  logic [2:0]       rd_layer;
  logic [7:0]       rd_seq;
  logic [1:0]       log_state;
  logic [4:0]       count;
  logic             overflow;
  logic [7:0]       dropped_cnt;
`ifdef TPU_LOG_TIMESTAMP_EN
  logic [15:0]      rd_timestamp;
`endif

  tpu_result_logger #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .clear         (clear),
    .mlp_state     (mlp_state),
    .mlp_layer     (mlp_layer),
    .mlp_acc_valid (mlp_acc_valid),
    .mlp_acc0      (mlp_acc0),
    .mlp_acc1      (mlp_acc1),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_acc0       (rd_acc0),
    .rd_acc1       (rd_acc1),
    .rd_layer      (rd_layer),
    .rd_seq        (rd_seq),
`ifdef TPU_LOG_TIMESTAMP_EN
    .rd_timestamp  (rd_timestamp),
`endif
    .log_state     (log_state),
    .count         (count),
    .overflow      (overflow),
    .dropped_cnt   (dropped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] acc0;
    logic [ACC_W-1:0] acc1;
    logic [2:0]       layer;
    logic [7:0]       seq;
    logic [15:0]      ts;
  } exp_rec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run-level state plus a queue of expected records.
  exp_rec_t exp_q[$];
  exp_rec_t last_pop;
  bit       model_ok = 0;
  int       m_state = 0;
  int       m_seq = 0;
  int       m_dropped = 0;
  int       m_ts = 0;
  bit       m_overflow = 0;
  bit       m_prev_valid = 0;

  always @(negedge clk) begin
    exp_rec_t h;
    bit       cap;
    bit       pop;
    // Monitor: compare what the DUT presents now.
    if (model_ok) begin
      h = (exp_q.size() != 0) ? exp_q[0] : last_pop;
      check("rd_valid", 64'(rd_valid), 64'(exp_q.size() != 0));
      check("count", 64'(count), 64'(exp_q.size()));
      check("log_state", 64'(log_state), 64'(m_state));
      check("overflow", 64'(overflow), 64'(m_overflow));
      check("dropped_cnt", 64'(dropped_cnt), 64'(m_dropped));
      check("rd_acc0", 64'(rd_acc0), 64'(h.acc0));
      check("rd_acc1", 64'(rd_acc1), 64'(h.acc1));
      check("rd_layer", 64'(rd_layer), 64'(h.layer));
      check("rd_seq", 64'(rd_seq), 64'(h.seq));
`ifdef TPU_LOG_TIMESTAMP_EN
      check("rd_timestamp", 64'(rd_timestamp), 64'(h.ts));
`endif
    end
    // Model: predict the effect of the upcoming rising edge.
    if (rst || clear) begin
      if (rst) model_ok = 1;
      exp_q.delete();
      last_pop = '{default: '0};
      m_state = 0; m_seq = 0; m_dropped = 0; m_ts = 0;
      m_overflow = 0; m_prev_valid = 0;
    end else if (model_ok) begin
      pop = (exp_q.size() != 0) && rd_ready;
      cap = (m_state == 2) && mlp_acc_valid && !m_prev_valid;
      if (pop) last_pop = exp_q.pop_front();
      if (cap) begin
        if (exp_q.size() == DEPTH) begin
          m_overflow = 1;
          if (m_dropped < 255) m_dropped++;
        end else begin
          exp_q.push_back('{mlp_acc0, mlp_acc1, mlp_layer, 8'(m_seq), 16'(m_ts)});
        end
        m_seq = (m_seq + 1) % 256;
      end
      m_prev_valid = mlp_acc_valid;
      case (m_state)
        0: if (arm) m_state = 1;
        1: if (mlp_state != 0) begin m_state = 2; m_ts = 0; end
        2: begin
             m_ts = (m_ts + 1) % 65536;
             if (mlp_state == 0) m_state = 3;
           end
        default: if (arm) m_state = 1;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [ACC_W-1:0] a0, input logic [ACC_W-1:0] a1,
                       input logic [2:0] layer, input int hold);
    mlp_acc0 = a0; mlp_acc1 = a1; mlp_layer = layer; mlp_acc_valid = 1'b1;
    repeat (hold) step();
    mlp_acc_valid = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic start_run();
    arm = 1'b1; step(); arm = 1'b0;
    mlp_state = 4'd1; step();
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    repeat (DEPTH + 2) step();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("reset_count", 64'(count), 64'd0);
    check("reset_state", 64'(log_state), 64'(IDLE));

    // Basic run with three distinct records.
    start_run();
    pulse(32'd100, 32'd200, 3'd0, 1);
    pulse(-32'sd5, 32'd9, 3'd1, 1);
    pulse(32'd7, -32'sd3, 3'd2, 1);
    mlp_state = 4'd0; step();
    check("basic_state", 64'(log_state), 64'(DONE));
    check("basic_count", 64'(count), 64'd3);
    check("basic_head_acc0", 64'(rd_acc0), 64'd100);
    check("basic_head_seq", 64'(rd_seq), 64'd0);
    drain();

    // Level-held valid gives exactly one record.
    do_clear();
    start_run();
    pulse(32'h1234, 32'h5678, 3'd3, 5);
    mlp_state = 4'd0; step();
    check("level_count", 64'(count), 64'd1);
    drain();

    // Pulses outside LOGGING are ignored.
    do_clear();
    pulse(32'd1, 32'd2, 3'd0, 1);
    arm = 1'b1; step(); arm = 1'b0;
    pulse(32'd3, 32'd4, 3'd1, 1);
    check("unarmed_count", 64'(count), 64'd0);
    check("unarmed_valid", 64'(rd_valid), 64'd0);

    // Overflow: 20 captures into a 16-entry buffer.
    do_clear();
    start_run();
    for (int i = 0; i < 20; i++) pulse($urandom, $urandom, 3'(i), 1);
    check("ovf_count", 64'(count), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_dropped", 64'(dropped_cnt), 64'd4);
    check("ovf_head_seq", 64'(rd_seq), 64'd0);

    // Full plus pop in the same cycle: no drop.
    mlp_acc0 = 32'hCAFE; mlp_acc1 = 32'hBEEF; mlp_acc_valid = 1'b1; rd_ready = 1'b1;
    step();
    mlp_acc_valid = 1'b0; rd_ready = 1'b0;
    step();
    check("fullpop_count", 64'(count), 64'd16);
    check("fullpop_dropped", 64'(dropped_cnt), 64'd4);
    mlp_state = 4'd0; step();
    drain();

    // Clear mid-run discards everything and restarts seq.
    do_clear();
    start_run();
    for (int i = 0; i < 5; i++) pulse($urandom, $urandom, 3'(i), 1);
    do_clear();
    check("clr_count", 64'(count), 64'd0);
    check("clr_state", 64'(log_state), 64'(IDLE));
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_valid", 64'(rd_valid), 64'd0);
    arm = 1'b1; step(); arm = 1'b0; step();
    pulse(32'd55, 32'd66, 3'd4, 1);
    check("rearm_seq", 64'(rd_seq), 64'd0);
    check("rearm_count", 64'(count), 64'd1);

    // Randomised traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      arm           = ($urandom_range(0, 15) == 0);
      clear         = ($urandom_range(0, 99) == 0);
      rst           = ($urandom_range(0, 499) == 0);
      mlp_acc_valid = $urandom_range(0, 1);
      rd_ready      = ($urandom_range(0, 3) == 0);
      mlp_acc0      = $urandom;
      mlp_acc1      = $urandom;
      mlp_layer     = 3'($urandom);
      if ($urandom_range(0, 15) == 0)
        mlp_state = (mlp_state == 4'd0) ? 4'($urandom_range(1, 15)) : 4'd0;
      step();
    end
    rst = 1'b0; clear = 1'b0; arm = 1'b0; mlp_acc_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
